// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the LSU and the AMO unit. AMO reads take
// priority, and the port stays locked to the AMO unit until its write-back.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_lsu_addr,
  input  logic                  i_lsu_rd_en,
  input  logic                  i_lsu_wr_en,
  input  logic [DATA_WIDTH-1:0] i_lsu_wdata,
  input  logic [3:0]            i_lsu_mask,
  output logic                  o_lsu_stall,
  output logic                  o_lsu_rvalid,
  output logic [DATA_WIDTH-1:0] o_lsu_rdata,
  input  logic [DATA_WIDTH-1:0] i_amo_addr,
  input  logic                  i_amo_rd_en,
  input  logic                  i_amo_wr_en,
  input  logic [DATA_WIDTH-1:0] i_amo_wdata,
  input  logic [3:0]            i_amo_mask,
  output logic                  o_is_data_loaded,
  output logic [DATA_WIDTH-1:0] o_amo_rdata,
  output logic                  o_amo_misaligned,
  output logic                  o_amo_addr_err,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd_en,
  output logic                  o_mem_wr_en,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_mask,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  // S_LSU_DONE is the lsu_rvalid cycle: the LSU still holds its read request
  // there, so the port must stay busy for one more cycle.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LSU_WAIT = 3'd1,
    S_LSU_DONE = 3'd2,
    S_AMO_WAIT = 3'd3,
    S_LOCKED   = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_lock_addr;

  logic w_lsu_req;
  logic w_amo_aligned;
  logic w_sel_amo_rd;
  logic w_sel_amo_wr;
  logic w_sel_lsu_rd;
  logic w_sel_lsu_wr;

  // Request selection and LSU stall for the current cycle
  always_comb begin
    w_lsu_req     = i_lsu_rd_en | i_lsu_wr_en;
    w_amo_aligned = (i_amo_addr[1:0] == 2'b00);
    w_sel_amo_rd  = 1'b0;
    w_sel_amo_wr  = 1'b0;
    w_sel_lsu_rd  = 1'b0;
    w_sel_lsu_wr  = 1'b0;
    o_lsu_stall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_amo_rd_en) begin
          w_sel_amo_rd = w_amo_aligned;
          o_lsu_stall  = w_lsu_req;
        end else if (i_lsu_rd_en) begin
          w_sel_lsu_rd = 1'b1;
        end else if (i_lsu_wr_en) begin
          w_sel_lsu_wr = 1'b1;
        end else begin
          o_lsu_stall = 1'b0;
        end
      end
      S_LOCKED: begin
        o_lsu_stall = w_lsu_req;
        if (i_amo_wr_en) begin
          w_sel_amo_wr = 1'b1;
        end else begin
          w_sel_amo_wr = 1'b0;
        end
      end
      default: begin
        o_lsu_stall = w_lsu_req;
      end
    endcase
  end

  // Memory request mux; all fields are zero when nothing is issued
  always_comb begin
    o_mem_rd_en = w_sel_amo_rd | w_sel_lsu_rd;
    o_mem_wr_en = w_sel_lsu_wr | w_sel_amo_wr;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_mask  = 4'b0000;
    if (w_sel_amo_rd) begin
      o_mem_addr = i_amo_addr;
      o_mem_mask = 4'b1111;
    end else if (w_sel_lsu_rd) begin
      o_mem_addr = i_lsu_addr;
      o_mem_mask = i_lsu_mask;
    end else if (w_sel_lsu_wr) begin
      o_mem_addr  = i_lsu_addr;
      o_mem_wdata = i_lsu_wdata;
      o_mem_mask  = i_lsu_mask;
    end else if (w_sel_amo_wr) begin
      o_mem_addr  = i_amo_addr;
      o_mem_wdata = i_amo_wdata;
      o_mem_mask  = i_amo_mask;
    end else begin
      o_mem_addr = '0;
    end
  end

  // Arbitration FSM with registered response data and status pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_lock_addr      <= '0;
      o_lsu_rvalid     <= 1'b0;
      o_lsu_rdata      <= '0;
      o_is_data_loaded <= 1'b0;
      o_amo_rdata      <= '0;
      o_amo_misaligned <= 1'b0;
      o_amo_addr_err   <= 1'b0;
    end else begin
      o_lsu_rvalid     <= 1'b0;
      o_is_data_loaded <= 1'b0;
      o_amo_misaligned <= 1'b0;
      o_amo_addr_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_amo_rd) begin
            r_lock_addr <= i_amo_addr;
            r_state     <= S_AMO_WAIT;
          end else if (i_amo_rd_en) begin
            o_amo_misaligned <= 1'b1;
          end else if (w_sel_lsu_rd) begin
            r_state <= S_LSU_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LSU_WAIT: begin
          if (i_mem_rvalid) begin
            o_lsu_rdata  <= i_mem_rdata;
            o_lsu_rvalid <= 1'b1;
            r_state      <= S_LSU_DONE;
          end else begin
            r_state <= S_LSU_WAIT;
          end
        end
        S_LSU_DONE: begin
          r_state <= S_IDLE;
        end
        S_AMO_WAIT: begin
          if (i_mem_rvalid) begin
            o_amo_rdata      <= i_mem_rdata;
            o_is_data_loaded <= 1'b1;
            r_state          <= S_LOCKED;
          end else begin
            r_state <= S_AMO_WAIT;
          end
        end
        S_LOCKED: begin
          if (w_sel_amo_wr) begin
            o_amo_addr_err <= (i_amo_addr != r_lock_addr);
            r_state        <= S_IDLE;
          end else begin
            r_state <= S_LOCKED;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: idle-state vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] lsu_addr, lsu_wdata, amo_addr, amo_wdata, mem_rdata;
  logic        lsu_rd_en, lsu_wr_en, amo_rd_en, amo_wr_en, mem_rvalid;
  logic [3:0]  lsu_mask, amo_mask;
  logic        lsu_stall, lsu_rvalid, is_data_loaded, amo_misaligned, amo_addr_err;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] lsu_rdata, amo_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_mask;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  dmem_arbiter #(.DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_lsu_addr(lsu_addr), .i_lsu_rd_en(lsu_rd_en), .i_lsu_wr_en(lsu_wr_en),
    .i_lsu_wdata(lsu_wdata), .i_lsu_mask(lsu_mask),
    .o_lsu_stall(lsu_stall), .o_lsu_rvalid(lsu_rvalid), .o_lsu_rdata(lsu_rdata),
    .i_amo_addr(amo_addr), .i_amo_rd_en(amo_rd_en), .i_amo_wr_en(amo_wr_en),
    .i_amo_wdata(amo_wdata), .i_amo_mask(amo_mask),
    .o_is_data_loaded(is_data_loaded), .o_amo_rdata(amo_rdata),
    .o_amo_misaligned(amo_misaligned), .o_amo_addr_err(amo_addr_err),
    .o_mem_addr(mem_addr), .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        lrd, lwr;
    logic [31:0] laddr, lwdata;
    logic [3:0]  lmask;
    logic        ard;
    logic [31:0] aaddr;
    logic        e_stall, e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;
    logic        e_mis_next;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv_idle();
    lsu_rd_en = 1'b0; lsu_wr_en = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_mask = 4'h0;
    amo_rd_en = 1'b0; amo_wr_en = 1'b0; amo_addr = 32'h0; amo_wdata = 32'h0; amo_mask = 4'h0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic cyc();
    @(negedge clk);
    drv_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drv_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Behavioural model state: what the port is busy with, as independent flags
  bit          m_lsu_out, m_lsu_resp, m_amo_out, m_locked;
  logic [31:0] m_lock, m_lsu_rdata, m_amo_rdata;
  logic        m_lsu_rv, m_loaded, m_mis, m_err;
  int          resp_cnt;
  logic [31:0] resp_data;

  initial begin
    rst = 1'b1;
    drv_idle();
    do_reset();

    // Reset state
    #1;
    chk("rst_stall", {31'd0, lsu_stall}, 32'd0);
    chk("rst_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
    chk("rst_lsu_rdata", lsu_rdata, 32'd0);
    chk("rst_loaded", {31'd0, is_data_loaded}, 32'd0);
    chk("rst_amo_rdata", amo_rdata, 32'd0);
    chk("rst_mis", {31'd0, amo_misaligned}, 32'd0);
    chk("rst_err", {31'd0, amo_addr_err}, 32'd0);
    chk("rst_mem", {mem_rd_en, mem_wr_en, mem_mask, 26'd0} | mem_addr | mem_wdata, 32'd0);

    // Idle-state vectors that never leave IDLE
    vt[0] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'h10, 32'hCAFE0001, 4'hF, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b1, 32'h10, 32'hCAFE0001, 4'hF, 1'b0};
    vt[2] = '{1'b0, 1'b1, 32'h14, 32'h12345678, 4'b0101, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b1, 32'h14, 32'h12345678, 4'b0101, 1'b0};
    vt[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h102,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 32'h18, 32'h0000AAAA, 4'hF, 1'b1, 32'h103,
              1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 32'h1C, 32'h0, 4'hF, 1'b1, 32'h101,
              1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1};
    vt[6] = '{1'b0, 1'b1, 32'h20, 32'hFFFF0000, 4'b1100, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b1, 32'h20, 32'hFFFF0000, 4'b1100, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cyc();
      lsu_rd_en = vt[i].lrd; lsu_wr_en = vt[i].lwr; lsu_addr = vt[i].laddr;
      lsu_wdata = vt[i].lwdata; lsu_mask = vt[i].lmask;
      amo_rd_en = vt[i].ard; amo_addr = vt[i].aaddr;
      #1;
      if (i > 0) chk("vec_mis", {31'd0, amo_misaligned}, {31'd0, vt[i-1].e_mis_next});
      chk("vec_stall", {31'd0, lsu_stall}, {31'd0, vt[i].e_stall});
      chk("vec_rd", {31'd0, mem_rd_en}, {31'd0, vt[i].e_rd});
      chk("vec_wr", {31'd0, mem_wr_en}, {31'd0, vt[i].e_wr});
      chk("vec_addr", mem_addr, vt[i].e_addr);
      chk("vec_wdata", mem_wdata, vt[i].e_wdata);
      chk("vec_mask", {28'd0, mem_mask}, {28'd0, vt[i].e_mask});
    end
    cyc(); #1;
    chk("vec_mis_last", {31'd0, amo_misaligned}, {31'd0, vt[6].e_mis_next});

    // AMO read of 0x100 with L=1, then write-back of 7
    cyc(); amo_rd_en = 1'b1; amo_addr = 32'h100; #1;
    chk("amo_rd_issue", {31'd0, mem_rd_en}, 32'd1);
    chk("amo_rd_addr", mem_addr, 32'h100);
    chk("amo_rd_mask", {28'd0, mem_mask}, 32'hF);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h5; #1;
    chk("amo_wait_no_rd", {31'd0, mem_rd_en}, 32'd0);
    cyc(); #1;
    chk("amo_loaded", {31'd0, is_data_loaded}, 32'd1);
    chk("amo_rdata", amo_rdata, 32'h5);
    cyc(); amo_wr_en = 1'b1; amo_addr = 32'h100; amo_wdata = 32'h7; amo_mask = 4'hF; #1;
    chk("amo_loaded_once", {31'd0, is_data_loaded}, 32'd0);
    chk("amo_wr_issue", {31'd0, mem_wr_en}, 32'd1);
    chk("amo_wr_addr", mem_addr, 32'h100);
    chk("amo_wr_data", mem_wdata, 32'h7);
    chk("amo_wr_mask", {28'd0, mem_mask}, 32'hF);
    cyc(); #1;
    chk("amo_no_err", {31'd0, amo_addr_err}, 32'd0);

    // Simultaneous LSU write and AMO read
    cyc(); lsu_wr_en = 1'b1; lsu_addr = 32'h40; lsu_wdata = 32'h1234; lsu_mask = 4'h3;
    amo_rd_en = 1'b1; amo_addr = 32'h200; #1;
    chk("sim_stall0", {31'd0, lsu_stall}, 32'd1);
    chk("sim_amo_rd", {mem_rd_en, mem_wr_en}, {2'b10});
    chk("sim_amo_addr", mem_addr, 32'h200);
    cyc(); lsu_wr_en = 1'b1; lsu_addr = 32'h40; lsu_wdata = 32'h1234; lsu_mask = 4'h3;
    mem_rvalid = 1'b1; mem_rdata = 32'h99; #1;
    chk("sim_stall1", {31'd0, lsu_stall}, 32'd1);
    cyc(); lsu_wr_en = 1'b1; lsu_addr = 32'h40; lsu_wdata = 32'h1234; lsu_mask = 4'h3; #1;
    chk("sim_stall2", {31'd0, lsu_stall}, 32'd1);
    chk("sim_no_wr", {31'd0, mem_wr_en}, 32'd0);
    cyc(); lsu_wr_en = 1'b1; lsu_addr = 32'h40; lsu_wdata = 32'h1234; lsu_mask = 4'h3;
    amo_wr_en = 1'b1; amo_addr = 32'h200; amo_wdata = 32'hAA; amo_mask = 4'hF; #1;
    chk("sim_stall_wr", {31'd0, lsu_stall}, 32'd1);
    chk("sim_amo_wr_addr", mem_addr, 32'h200);
    cyc(); lsu_wr_en = 1'b1; lsu_addr = 32'h40; lsu_wdata = 32'h1234; lsu_mask = 4'h3; #1;
    chk("sim_stall_free", {31'd0, lsu_stall}, 32'd0);
    chk("sim_lsu_wr", {31'd0, mem_wr_en}, 32'd1);
    chk("sim_lsu_addr", mem_addr, 32'h40);
    chk("sim_lsu_wdata", mem_wdata, 32'h1234);
    chk("sim_lsu_mask", {28'd0, mem_mask}, 32'h3);

    // LSU read of 0x20 with L=3; AMO read raised meanwhile waits
    cyc(); lsu_rd_en = 1'b1; lsu_addr = 32'h20; lsu_mask = 4'hF; #1;
    chk("lrd_issue", {31'd0, mem_rd_en}, 32'd1);
    chk("lrd_addr", mem_addr, 32'h20);
    chk("lrd_stall0", {31'd0, lsu_stall}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); lsu_rd_en = 1'b1; lsu_addr = 32'h20; lsu_mask = 4'hF;
      amo_rd_en = 1'b1; amo_addr = 32'h300;
      if (k == 3) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; end
      #1;
      chk("lrd_wait_no_rd", {31'd0, mem_rd_en}, 32'd0);
      chk("lrd_wait_stall", {31'd0, lsu_stall}, 32'd1);
    end
    cyc(); lsu_rd_en = 1'b1; lsu_addr = 32'h20; lsu_mask = 4'hF;
    amo_rd_en = 1'b1; amo_addr = 32'h300; #1;
    chk("lrd_rvalid", {31'd0, lsu_rvalid}, 32'd1);
    chk("lrd_rdata", lsu_rdata, 32'hDEADBEEF);
    chk("lrd_resp_stall", {31'd0, lsu_stall}, 32'd1);
    chk("lrd_resp_no_rd", {31'd0, mem_rd_en}, 32'd0);
    cyc(); amo_rd_en = 1'b1; amo_addr = 32'h300; #1;
    chk("lrd_rvalid_once", {31'd0, lsu_rvalid}, 32'd0);
    chk("lrd_amo_after", {31'd0, mem_rd_en}, 32'd1);
    chk("lrd_amo_addr", mem_addr, 32'h300);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h3;
    cyc(); #1;
    chk("lrd_amo_loaded", {31'd0, is_data_loaded}, 32'd1);
    cyc(); amo_wr_en = 1'b1; amo_addr = 32'h300; amo_mask = 4'hF; amo_wdata = 32'h4;

    // Misaligned AMO held for two cycles, then dropped
    cyc(); amo_rd_en = 1'b1; amo_addr = 32'h102; #1;
    chk("mis_no_rd", {31'd0, mem_rd_en}, 32'd0);
    cyc(); amo_rd_en = 1'b1; amo_addr = 32'h102; #1;
    chk("mis_pulse1", {31'd0, amo_misaligned}, 32'd1);
    cyc(); #1;
    chk("mis_pulse2", {31'd0, amo_misaligned}, 32'd1);
    cyc(); lsu_wr_en = 1'b1; lsu_addr = 32'h44; #1;
    chk("mis_clear", {31'd0, amo_misaligned}, 32'd0);
    chk("mis_idle_wr", {31'd0, mem_wr_en}, 32'd1);

    // Address mismatch on write-back
    cyc(); amo_rd_en = 1'b1; amo_addr = 32'h100;
    cyc();
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h11;
    cyc(); amo_wr_en = 1'b1; amo_addr = 32'h104; amo_wdata = 32'h22; amo_mask = 4'hF; #1;
    chk("err_rdata", amo_rdata, 32'h11);
    chk("err_wr_issue", {31'd0, mem_wr_en}, 32'd1);
    chk("err_wr_addr", mem_addr, 32'h104);
    chk("err_wr_data", mem_wdata, 32'h22);
    cyc(); #1;
    chk("err_pulse", {31'd0, amo_addr_err}, 32'd1);
    cyc(); #1;
    chk("err_once", {31'd0, amo_addr_err}, 32'd0);

    // Reset during AMO_WAIT; the late response must be ignored
    cyc(); amo_rd_en = 1'b1; amo_addr = 32'h400; #1;
    chk("rmo_issue", {31'd0, mem_rd_en}, 32'd1);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
    chk("rmo_rdata_cleared", amo_rdata, 32'd0);
    chk("rmo_lsu_rdata_cleared", lsu_rdata, 32'd0);
    cyc(); lsu_wr_en = 1'b1; lsu_addr = 32'h80; lsu_wdata = 32'h0BADF00D; lsu_mask = 4'hF; #1;
    chk("rmo_no_loaded", {31'd0, is_data_loaded}, 32'd0);
    chk("rmo_rdata_kept", amo_rdata, 32'd0);
    chk("rmo_lsu_stall", {31'd0, lsu_stall}, 32'd0);
    chk("rmo_lsu_wr", {31'd0, mem_wr_en}, 32'd1);
    chk("rmo_lsu_addr", mem_addr, 32'h80);

    // Randomized traffic against the behavioural model
    do_reset();
    m_lsu_out = 1'b0; m_lsu_resp = 1'b0; m_amo_out = 1'b0; m_locked = 1'b0;
    m_lock = 32'h0; m_lsu_rdata = 32'h0; m_amo_rdata = 32'h0;
    m_lsu_rv = 1'b0; m_loaded = 1'b0; m_mis = 1'b0; m_err = 1'b0;
    resp_cnt = -1; resp_data = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      logic        busy, lreq;
      logic        e_stall, e_rd, e_wr;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_mask;
      cyc();
      if (resp_cnt > 0) resp_cnt--;
      if (resp_cnt == 0) begin
        mem_rvalid = 1'b1; mem_rdata = resp_data; resp_cnt = -1;
      end else if (resp_cnt < 0 && !m_lsu_out && !m_amo_out && ($urandom % 8 == 0)) begin
        mem_rvalid = 1'b1; mem_rdata = $urandom;
      end
      lsu_rd_en = ($urandom % 4 == 0);
      lsu_wr_en = ($urandom % 3 == 0);
      lsu_addr = $urandom; lsu_wdata = $urandom; lsu_mask = 4'($urandom);
      amo_rd_en = ($urandom % 5 == 0);
      amo_addr = ($urandom & 32'h0000_0FFC) | (($urandom % 4 == 0) ? 32'($urandom % 4) : 32'h0);
      amo_wdata = $urandom; amo_mask = 4'($urandom);
      if (m_locked && ($urandom % 3 == 0)) begin
        amo_wr_en = 1'b1;
        amo_addr = ($urandom % 4 == 0) ? m_lock + 32'h4 : m_lock;
      end
      #1;
      busy = m_lsu_out | m_lsu_resp | m_amo_out | m_locked;
      lreq = lsu_rd_en | lsu_wr_en;
      e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_mask = 4'h0;
      if (!busy) begin
        if (amo_rd_en) begin
          e_stall = lreq;
          if (amo_addr[1:0] == 2'b00) begin
            e_rd = 1'b1; e_addr = amo_addr; e_mask = 4'hF;
          end
        end else if (lsu_rd_en) begin
          e_rd = 1'b1; e_addr = lsu_addr; e_mask = lsu_mask;
        end else if (lsu_wr_en) begin
          e_wr = 1'b1; e_addr = lsu_addr; e_wdata = lsu_wdata; e_mask = lsu_mask;
        end
      end else begin
        e_stall = lreq;
        if (m_locked && amo_wr_en) begin
          e_wr = 1'b1; e_addr = amo_addr; e_wdata = amo_wdata; e_mask = amo_mask;
        end
      end
      chk("rnd_stall", {31'd0, lsu_stall}, {31'd0, e_stall});
      chk("rnd_rd", {31'd0, mem_rd_en}, {31'd0, e_rd});
      chk("rnd_wr", {31'd0, mem_wr_en}, {31'd0, e_wr});
      chk("rnd_addr", mem_addr, e_addr);
      chk("rnd_wdata", mem_wdata, e_wdata);
      chk("rnd_mask", {28'd0, mem_mask}, {28'd0, e_mask});
      chk("rnd_lsu_rvalid", {31'd0, lsu_rvalid}, {31'd0, m_lsu_rv});
      chk("rnd_lsu_rdata", lsu_rdata, m_lsu_rdata);
      chk("rnd_loaded", {31'd0, is_data_loaded}, {31'd0, m_loaded});
      chk("rnd_amo_rdata", amo_rdata, m_amo_rdata);
      chk("rnd_mis", {31'd0, amo_misaligned}, {31'd0, m_mis});
      chk("rnd_err", {31'd0, amo_addr_err}, {31'd0, m_err});
      if (mem_rd_en) begin
        resp_cnt = 1 + int'($urandom % 4);
        resp_data = $urandom;
      end
      // Advance the model to what the next clock edge should produce
      m_lsu_rv = m_lsu_out && mem_rvalid;
      if (m_lsu_rv) m_lsu_rdata = mem_rdata;
      m_loaded = m_amo_out && mem_rvalid;
      if (m_loaded) m_amo_rdata = mem_rdata;
      m_mis = !busy && amo_rd_en && (amo_addr[1:0] != 2'b00);
      m_err = m_locked && amo_wr_en && (amo_addr != m_lock);
      if (!busy) begin
        if (amo_rd_en && amo_addr[1:0] == 2'b00) begin
          m_amo_out = 1'b1; m_lock = amo_addr;
        end else if (!amo_rd_en && lsu_rd_en) begin
          m_lsu_out = 1'b1;
        end
      end else if (m_lsu_out && mem_rvalid) begin
        m_lsu_out = 1'b0; m_lsu_resp = 1'b1;
      end else if (m_lsu_resp) begin
        m_lsu_resp = 1'b0;
      end else if (m_amo_out && mem_rvalid) begin
        m_amo_out = 1'b0; m_locked = 1'b1;
      end else if (m_locked && amo_wr_en) begin
        m_locked = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Data-memory port arbiter between the load/store unit (LSU) and the atomic memory operation unit (AMO). It sits directly downstream of the AMO unit and owns the single data-memory port. It serialises requests and returns load data to the AMO unit together with its `is_data_loaded` pulse. It also locks the port between an AMO's read and its write-back, so that no LSU access can intervene.

## Interface
- `DATA_WIDTH`, 32: data and address width in bits.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `lsu_addr` in DATA_WIDTH: LSU byte address.
- `lsu_rd_en` in 1: LSU read request; held until `lsu_rvalid`.
- `lsu_wr_en` in 1: LSU write request; held while `lsu_stall`.
- `lsu_wdata` in DATA_WIDTH: LSU write data.
- `lsu_mask` in 4: LSU byte enables.
- `lsu_stall` out 1: LSU request is present but is not accepted this cycle.
- `lsu_rvalid` out 1: one-cycle pulse; `lsu_rdata` is valid.
- `lsu_rdata` out DATA_WIDTH: LSU load data.
- `amo_addr`, `amo_rd_en`, `amo_wr_en`, `amo_wdata`, `amo_mask` in (DATA_WIDTH, 1, 1, DATA_WIDTH, 4): AMO memory request fields.
- `is_data_loaded` out 1: one-cycle pulse to the AMO unit; `amo_rdata` is valid.
- `amo_rdata` out DATA_WIDTH: AMO load data (the old memory value).
- `amo_misaligned` out 1: one-cycle pulse; the AMO read address is not word-aligned.
- `amo_addr_err` out 1: one-cycle pulse; the AMO write address differs from the locked read address.
- `mem_addr`, `mem_rd_en`, `mem_wr_en`, `mem_wdata`, `mem_mask` out (DATA_WIDTH, 1, 1, DATA_WIDTH, 4): request to data memory.
- `mem_rvalid` in 1: memory read response valid. Latency L≥1 cycles after `mem_rd_en`.
- `mem_rdata` in DATA_WIDTH: memory read data.

## Operation
- **States:**
  - `IDLE`: free.
  - `LSU_WAIT`: LSU read outstanding.
  - `AMO_WAIT`: AMO read outstanding.
  - `LOCKED`: AMO read done; waiting for the AMO write.
- **`IDLE` priority:** AMO first, then LSU.
  - **AMO read, aligned:** `amo_rd_en` with `amo_addr[1:0]==0`.
    - Issue `mem_rd_en=1`, `mem_addr=amo_addr`, `mem_mask=4'b1111`.
    - Latch `lock_addr=amo_addr` and go to `AMO_WAIT`.
  - **AMO read, misaligned:** `amo_rd_en` with `amo_addr[1:0]!=0`.
    - No memory access.
    - Registered `amo_misaligned` pulse next cycle.
    - Stay in `IDLE`. The AMO unit must drop the request; while it is held, the pulse repeats every cycle.
  - **LSU write, no AMO request:** drive the `mem_*` write fields from `lsu_*`; `lsu_stall=0`; stay in `IDLE`.
  - **LSU read, no AMO request:** issue the read and go to `LSU_WAIT`.
  - **LSU rd and wr both high:** read wins.
- **`LSU_WAIT`:**
  - No new memory requests.
  - `lsu_stall=1` for any LSU request.
  - On `mem_rvalid`: register `lsu_rdata<=mem_rdata` and pulse `lsu_rvalid` the next cycle. `lsu_stall` is held at 1 through that cycle, then the block returns to `IDLE`.
  - An AMO request arriving in this state waits; it is not dropped.
- **`AMO_WAIT`:**
  - No new memory requests; `lsu_stall=1`.
  - On `mem_rvalid`: register `amo_rdata<=mem_rdata` and pulse `is_data_loaded` the next cycle; go to `LOCKED`.
- **`LOCKED`:**
  - `lsu_stall=1`.
  - On `amo_wr_en`: issue the write the same cycle with `mem_addr=amo_addr`, `mem_wdata=amo_wdata`, `mem_mask=amo_mask`; go to `IDLE`.
  - If `amo_addr!=lock_addr`, the write is still performed and `amo_addr_err` pulses next cycle.
  - `amo_rd_en` in `LOCKED` is ignored.
- **`mem_*` outputs:** combinational from state and the selected requester. When no request is issued they are 0 (address and data 0 too).
- **Stray responses:** `mem_rvalid` in `IDLE` or `LOCKED` is ignored; the stored data is not changed.

## Timing
- **Reset values:** state `IDLE`. All pulse outputs 0. `lsu_rdata`, `amo_rdata` and `lock_addr` are 0. `mem_*` are 0.
- **Reset mid-operation:** any outstanding read is abandoned. Its later `mem_rvalid` arrives in `IDLE` and is ignored.
- **AMO read latency:** `amo_rd_en` accepted at cycle t → `mem_rd_en` at t → `mem_rvalid` at t+L → `is_data_loaded` and `amo_rdata` at t+L+1.
- **AMO write latency:** `amo_wr_en` in `LOCKED` at cycle w → `mem_wr_en` at w. The port is free to the LSU at w+1.
- **LSU read latency:** `lsu_rvalid` at t+L+1. LSU write: zero added latency when the port is free.
- **Lock window:** the LSU sees `lsu_stall=1` from the cycle the AMO read is issued up to and including the AMO write cycle.
- **One outstanding read** at any time.

## Test plan
- **AMO read:** `amo_rd_en` with `amo_addr=0x100`, L=1, `mem_rdata=0x0000_0005` → `mem_rd_en` at t; `is_data_loaded=1` and `amo_rdata=5` at t+2. Then `amo_wr_en` with data 0x7 → `mem_wr_en=1`, `mem_addr=0x100`, `mem_wdata=7`, `mem_mask=4'b1111`.
- **Simultaneous requests:** `lsu_wr_en` and `amo_rd_en` in the same `IDLE` cycle → AMO read issued; `lsu_stall=1` until the AMO write cycle; the LSU write is issued the following cycle.
- **LSU read:** `lsu_rd_en` with `lsu_addr=0x20`, L=3, `mem_rdata=0xDEADBEEF` → `lsu_rvalid` 4 cycles later with `lsu_rdata=0xDEADBEEF`. An AMO request raised meanwhile is issued only after that.
- **Misaligned AMO:** `amo_addr=0x102` → no `mem_rd_en`; `amo_misaligned` pulses next cycle; state stays `IDLE`.
- **Address mismatch:** AMO write to 0x104 after a read of 0x100 → write is issued to 0x104; `amo_addr_err` pulses once.
- **Reset mid-operation:** `rst` during `AMO_WAIT`, then `mem_rvalid` → `is_data_loaded` stays 0 and `amo_rdata` stays 0; an LSU write the next cycle is accepted with `lsu_stall=0`.
